// File: rtl/divider_frontend.sv
// Request/response wrapper for a fixed-latency 33-bit signed divider: operand
// widening, in-flight tracking, credit-based flow control and an ordered result FIFO.
module divider_frontend #(
   parameter int unsigned LATENCY    = 4,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned TAG_WIDTH  = 4
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_a,
   input  logic [31:0]          in_b,
   input  logic                 in_signed,
   input  logic                 in_rem,
   input  logic [TAG_WIDTH-1:0] in_tag,
   output logic [32:0]          div_numer,
   output logic [32:0]          div_denom,
   input  logic [32:0]          div_quotient,
   input  logic [32:0]          div_remain,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_data,
   output logic [TAG_WIDTH-1:0] out_tag
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [PW-1:0] LAST_IDX = PW'(FIFO_DEPTH - 1);

   logic                 accept;
   logic                 deq;
   logic                 push;
   logic [31:0]          push_data;
   logic [CW-1:0]        count;
   logic [CW-1:0]        fill;
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic                 fifo_full;
   logic [LATENCY-1:0]   trk_valid;
   logic [LATENCY-1:0]   trk_rem;
   logic [TAG_WIDTH-1:0] trk_tag  [LATENCY];
   logic [31:0]          mem_data [FIFO_DEPTH];
   logic [TAG_WIDTH-1:0] mem_tag  [FIFO_DEPTH];
   logic                 unused_hi;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_IDX) ? '0 : p + PW'(1);
   endfunction

   assign div_numer = {in_signed & in_a[31], in_a};
   assign div_denom = {in_signed & in_b[31], in_b};

   // The divider resolves /0 and overflow itself; only the low 32 bits are used.
   assign unused_hi = div_quotient[32] ^ div_remain[32];

   assign in_ready  = (count != FULL_CNT);
   assign accept    = in_valid && in_ready;
   assign out_valid = (fill != '0);
   assign deq       = out_valid && out_ready;
   assign fifo_full = (fill == FULL_CNT);
   assign out_data  = mem_data[rd_ptr];
   assign out_tag   = mem_tag[rd_ptr];

   assign push      = trk_valid[LATENCY-1];
   assign push_data = trk_rem[LATENCY-1] ? div_remain[31:0] : div_quotient[31:0];

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         trk_valid <= '0;
      end else begin
         trk_valid[0] <= accept;
         for (int unsigned i = 1; i < LATENCY; i++) begin
            trk_valid[i] <= trk_valid[i-1];
         end
      end
   end

   always_ff @(posedge clock) begin
      trk_rem[0] <= in_rem;
      trk_tag[0] <= in_tag;
      for (int unsigned i = 1; i < LATENCY; i++) begin
         trk_rem[i] <= trk_rem[i-1];
         trk_tag[i] <= trk_tag[i-1];
      end
   end

   // Credits cover both in-flight operations and FIFO occupancy, so a push never finds the FIFO full.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         count <= '0;
      end else begin
         case ({accept, deq})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (deq)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, deq})
            2'b10:   fill <= fill + CW'(1);
            2'b01:   fill <= fill - CW'(1);
            default: fill <= fill;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         mem_data[wr_ptr] <= push_data;
         mem_tag[wr_ptr]  <= trk_tag[LATENCY-1];
      end
   end

   a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
                                   !(push && fifo_full && !deq));

endmodule

// File: tb/tb_divider_frontend.sv
// Scoreboard bench for divider_frontend with a behavioural 4-cycle divider model.
module tb_divider_frontend;

   localparam int LAT = 4;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        in_signed;
   logic        in_rem;
   logic [3:0]  in_tag;
   logic [32:0] div_numer;
   logic [32:0] div_denom;
   logic [32:0] div_quotient;
   logic [32:0] div_remain;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_tag;

   int          checks = 0;
   int          errors = 0;
   logic [35:0] exp_q[$];
   logic [32:0] dq_q [LAT];
   logic [32:0] dq_r [LAT];
   logic        stream_mode = 1'b0;
   int          stream_cyc, gaps, cnt_bad;

   divider_frontend #(.LATENCY(4), .FIFO_DEPTH(8), .TAG_WIDTH(4)) dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_rem(in_rem), .in_tag(in_tag),
      .div_numer(div_numer), .div_denom(div_denom),
      .div_quotient(div_quotient), .div_remain(div_remain),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
   );

   always #5 clock = ~clock;

   function automatic logic [65:0] div33(input logic [32:0] n, input logic [32:0] d);
      logic signed [32:0] sn, sd, q, r;
      sn = n;
      sd = d;
      if (d == '0) begin
         q = '1;
         r = sn;
      end else begin
         q = sn / sd;
         r = sn % sd;
      end
      return {q, r};
   endfunction

   // Divider model: operands sampled at an edge appear LAT edges later.
   always @(posedge clock) begin
      logic [65:0] res;
      res = div33(div_numer, div_denom);
      dq_q[0] <= res[65:33];
      dq_r[0] <= res[32:0];
      for (int i = 1; i < LAT; i++) begin
         dq_q[i] <= dq_q[i-1];
         dq_r[i] <= dq_r[i-1];
      end
   end
   assign div_quotient = dq_q[LAT-1];
   assign div_remain   = dq_r[LAT-1];

   function automatic logic [31:0] rv_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input logic rm);
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      if (b == '0) return rm ? a : 32'hFFFF_FFFF;
      if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rm ? 32'h0 : 32'h8000_0000;
      if (s) return rm ? 32'(sa % sb) : 32'(sa / sb);
      return rm ? (a % b) : (a / b);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         logic [35:0] e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got data %h tag %h expected none", out_data, out_tag);
         end else begin
            e = exp_q.pop_front();
            if ({out_data, out_tag} !== e) begin
               errors++;
               $display("FAIL result: got data %h tag %h expected data %h tag %h",
                        out_data, out_tag, e[35:4], e[3:0]);
            end
         end
      end
   end

   always @(negedge clock) begin
      if (stream_mode) begin
         stream_cyc++;
         if (stream_cyc >= 6) begin
            if (!out_valid) gaps++;
            if (dut.count != 4'd5) cnt_bad++;
         end
      end
   end

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input logic rm,
                       input logic [3:0] tag, input logic [31:0] exp, input int budget);
      int waits;
      in_valid  = 1'b1;
      in_a      = a;
      in_b      = b;
      in_signed = s;
      in_rem    = rm;
      in_tag    = tag;
      waits     = 0;
      @(negedge clock);
      while (!in_ready && waits < budget) begin
         waits++;
         @(negedge clock);
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got in_ready 0 expected 1 (tag %h)", tag);
         in_valid = 1'b0;
         step();
      end else begin
         @(posedge clock);
         exp_q.push_back({exp, tag});
         #1;
      end
   endtask

   task automatic drain(input string name);
      int n;
      out_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clock);
         n++;
      end
      chk(name, exp_q.size(), 0);
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k, hi, vis;
      logic [31:0] a, b;
      logic s, rm;

      reset_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
      in_signed = 1'b0; in_rem = 1'b0; in_tag = '0; out_ready = 1'b0;
      repeat (3) step();
      reset_n = 1'b1;
      @(negedge clock);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_count", dut.count, 0);
      step();

      // Directed vectors and first-result latency
      out_ready = 1'b1;
      send(32'hFFFF_FFF9, 32'd2, 1, 0, 4'd1, 32'hFFFF_FFFD, 0);
      in_valid = 1'b0;
      k = 0;
      do begin
         @(negedge clock);
         k++;
      end while (!out_valid && k < 20);
      chk("first_latency", k, 5);
      drain("drain_first");

      send(32'hFFFF_FFF9, 32'd2,          1, 1, 4'd2, 32'hFFFF_FFFF, 0);
      send(32'hFFFF_FFFF, 32'd2,          0, 0, 4'd3, 32'h7FFF_FFFF, 0);
      send(32'd7,         32'd0,          0, 1, 4'd4, 32'd7,         0);
      send(32'd5,         32'd0,          0, 0, 4'd5, 32'hFFFF_FFFF, 0);
      send(32'd5,         32'd0,          1, 0, 4'd6, 32'hFFFF_FFFF, 0);
      send(32'h8000_0000, 32'hFFFF_FFFF,  1, 0, 4'd7, 32'h8000_0000, 0);
      send(32'h8000_0000, 32'hFFFF_FFFF,  1, 1, 4'd8, 32'h0,         0);
      in_valid = 1'b0;
      drain("drain_directed");

      // Backpressure: eight credits, then stall until the consumer drains
      out_ready = 1'b0;
      for (int t = 0; t < 8; t++) send(32'd100 + t, 32'd1, 0, 0, 4'(t), 32'd100 + t, 0);
      in_a = 32'd108; in_b = 32'd1; in_signed = 1'b0; in_rem = 1'b0; in_tag = 4'd8;
      hi = 0;
      repeat (6) begin
         @(negedge clock);
         if (in_ready) hi++;
      end
      chk("bp_in_ready_low", hi, 0);
      chk("bp_count_full", dut.count, 8);
      step();
      out_ready = 1'b1;
      send(32'd108, 32'd1, 0, 0, 4'd8, 32'd108, 20);
      send(32'd109, 32'd1, 0, 0, 4'd9, 32'd109, 20);
      in_valid = 1'b0;
      drain("drain_backpressure");

      // Streaming: one accept and one result per cycle
      stream_cyc = 0; gaps = 0; cnt_bad = 0;
      stream_mode = 1'b1;
      for (int i = 0; i < 100; i++) begin
         a  = $urandom;
         b  = (i % 13 == 0) ? 32'd0 : ((i % 5 == 1) ? 32'($urandom_range(1, 9)) : $urandom);
         s  = 1'($urandom_range(0, 1));
         rm = 1'($urandom_range(0, 1));
         if (i == 7) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; s = 1'b1; end
         if (i % 7 == 3) a = -a;
         send(a, b, s, rm, 4'(i), rv_ref(a, b, s, rm), 0);
      end
      stream_mode = 1'b0;
      in_valid = 1'b0;
      chk("stream_out_gaps", gaps, 0);
      chk("stream_count_not5", cnt_bad, 0);
      drain("drain_stream");

      // Reset with two results queued and three in flight
      out_ready = 1'b0;
      send(32'd20, 32'd4, 0, 0, 4'hA, 32'd5, 0);
      send(32'd21, 32'd4, 0, 1, 4'hB, 32'd1, 0);
      in_valid = 1'b0;
      repeat (6) step();
      send(32'd30, 32'd3, 0, 0, 4'hC, 32'd10, 0);
      send(32'd31, 32'd3, 0, 0, 4'hD, 32'd10, 0);
      send(32'd32, 32'd3, 0, 0, 4'hE, 32'd10, 0);
      in_valid = 1'b0;
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      exp_q.delete();
      @(negedge clock);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_count", dut.count, 0);
      step();
      out_ready = 1'b1;
      vis = 0;
      repeat (8) begin
         @(negedge clock);
         if (out_valid) vis++;
      end
      chk("rst_no_stale_results", vis, 0);
      step();
      send(32'd9, 32'd3, 0, 0, 4'h3, 32'd3, 0);
      in_valid = 1'b0;
      drain("drain_after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/divider_frontend.md
# divider_frontend

Request/response wrapper around the fixed-latency pipelined signed divider. Accepts 32-bit RISC-V style DIV/DIVU/REM/REMU requests on a ready/valid port, widens operands to the divider's 33-bit signed domain, and tracks in-flight operations with a valid/tag shift pipeline. Results are captured into an output FIFO with backpressure. The block sits between the execute-stage issue logic and the divider, and owns all flow control the divider lacks.

## Interface
- LATENCY, 4: divider latency in cycles; must equal the divider instance's LATENCY.
- FIFO_DEPTH, 8: result FIFO entries; constraint FIFO_DEPTH ≥ LATENCY+1.
- TAG_WIDTH, 4: width of the opaque request tag.
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_a  in  32  dividend.
- in_b  in  32  divisor.
- in_signed  in  1  1 = signed op (DIV/REM), 0 = unsigned (DIVU/REMU).
- in_rem  in  1  1 = return remainder, 0 = return quotient.
- in_tag  in  TAG_WIDTH  tag returned with the result.
- div_numer  out  33  to divider numer.
- div_denom  out  33  to divider denom.
- div_quotient  in  33  from divider quotient.
- div_remain  in  33  from divider remain.
- out_valid  out  1  result at FIFO head.
- out_ready  in  1  consumer takes result when out_valid && out_ready.
- out_data  out  32  result.
- out_tag  out  TAG_WIDTH  tag of the result.

## Operation
- Operand widening, combinational from inputs: signed → bit 32 = bit 31; unsigned → bit 32 = 0. div_numer/div_denom follow in_a/in_b every cycle, regardless of in_valid.
- Divide-by-zero and signed overflow are resolved by the divider: x/0 gives quotient all-ones and remainder x; 0x80000000/-1 gives quotient 0x80000000 and remainder 0. The block only truncates results to [31:0].
- Track pipeline: LATENCY stages of {valid, rem, tag}. Stage 0 loads {accept, in_rem, in_tag} each cycle; the other stages shift.
- At the last stage, if valid, push {rem ? div_remain[31:0] : div_quotient[31:0], tag} into the FIFO.
- Credit counter `count`, width clog2(FIFO_DEPTH+1), holds in-flight plus FIFO occupancy:
  - +1 on accept, −1 on dequeue.
  - Simultaneous accept and dequeue: unchanged.
- in_ready = (count != FIFO_DEPTH). It depends on registers only; there is no path from out_ready or in_valid.
- Because of the credit scheme, the FIFO never overflows. A push when full is a verification error.
- FIFO: circular buffer, read/write pointers wrap modulo FIFO_DEPTH. out_valid = not empty; out_data/out_tag = head entry. Push and pop in the same cycle are both legal, including when empty-then-push or full.
- Results leave in request order; no reordering.
- Reset (reset_n = 0 at a rising edge):
  - Clears all track valid bits, FIFO pointers and count.
  - Results still inside the divider from before reset are discarded because their valid bits are cleared.
  - Reset mid-operation loses all outstanding requests by design.

## Timing
- Reset values: out_valid 0, in_ready 1, count 0. out_data/out_tag are don't-care while out_valid = 0.
- Request accepted in cycle c → divider result visible in cycle c+LATENCY → FIFO write at the end of that cycle → out_valid earliest in cycle c+LATENCY+1.
- Throughput: one accept per cycle, sustained indefinitely when out_ready = 1 (needs FIFO_DEPTH ≥ LATENCY+1).
- in_ready deasserts in the cycle after count reaches FIFO_DEPTH. It reasserts in the cycle after the first dequeue.
- Dequeue on cycle d: the next entry, if present, is at the head in cycle d+1.

## Test plan
All scenarios use LATENCY=4, FIFO_DEPTH=8.
- Signed: DIV −7/2 tag 1, accepted in cycle 0 → out_valid in cycle 5, out_data 0xFFFFFFFD, tag 1. REM −7/2 → 0xFFFFFFFF.
- Unsigned: DIVU 0xFFFFFFFF/2 → 0x7FFFFFFF. REMU 7/0 → 7. DIVU 5/0 → 0xFFFFFFFF. DIV 5/0 → 0xFFFFFFFF.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same operands → 0.
- Backpressure: out_ready = 0, 10 back-to-back requests tagged 0..9 → exactly 8 accepted, then in_ready = 0. Raise out_ready → tags 0..7 emerge in order, then 8 and 9 are accepted and emerge; no loss or duplication.
- Streaming: 100 random requests, in_valid and out_ready held at 1 → in_ready never drops and one result per cycle after a 5-cycle fill. Simultaneous push/pop with count constant at 5; results match a reference model.
- Reset mid-operation: 3 requests in flight and 2 queued, reset_n low for one cycle → out_valid = 0, in_ready = 1, and no result appears for the next 8 cycles without new requests.
